tt_response_checker: RTL and testbench

Synthesizable on-board checker for small combinational lab DUTs. It receives each applied input vector from a stimulus source, waits a settle interval, then samples the DUT response and compares it with a parameterised expected truth table. It tracks which vectors have been covered, counts mismatches, and captures the first failure. It reports done/pass once every input code has been checked. It sits between the stimulus counter and the DUT outputs (LEDs/UART report downstream).

---
 rtl/tt_response_checker.sv | 173 +++++++++++++++++
 tb/tb_tt_response_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tt_response_checker.sv
// On-board response checker: samples a combinational DUT after a settle delay and compares it against a truth table.
// Optional idle watchdog is compiled in with `define TT_TIMEOUT_EN.
`timescale 1ns/1ps
module tt_response_checker #(
    parameter int                           N_IN      = 3,
    parameter int                           N_OUT     = 3,
    parameter logic [(2**N_IN)*N_OUT-1:0]   EXP_TABLE = 24'hF93458,
    parameter int                           SETTLE    = 2,
    parameter int                           ERR_W     = 8,
    parameter int                           TIMEOUT   = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [N_IN-1:0]  vec_in,
    input  logic [N_OUT-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [N_IN-1:0]  first_err_vec,
    output logic [N_OUT-1:0] first_err_resp,
    output logic             timeout
);

    localparam int DEPTH = 2**N_IN;
    localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DEPTH-1:0]   cov_q, cov_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fev_q, fev_d;
    logic [N_IN-1:0]    fvec_q, fvec_d;
    logic [N_OUT-1:0]   fresp_q, fresp_d;
    logic [N_OUT-1:0]   exp_resp;
    logic               to_flag;

`ifdef TT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]      idle_q, idle_d;
    logic               timeout_q, timeout_d;
    assign to_flag = timeout_q;
`else
    assign to_flag = 1'b0;
`endif

    assign exp_resp = EXP_TABLE[int'(vec_q)*N_OUT +: N_OUT];

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        cov_d   = cov_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fvec_d  = fvec_q;
        fresp_d = fresp_q;
`ifdef TT_TIMEOUT_EN
        idle_d    = idle_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_ARMED: begin
                if (vec_valid) begin
                    vec_d = vec_in;
                    if (SETTLE > 0) begin
                        state_d = S_SETTLE;
                        cnt_d   = CW'(SETTLE - 1);
                    end else begin
                        state_d = S_CHECK;
                    end
`ifdef TT_TIMEOUT_EN
                    idle_d = '0;
`endif
                end
`ifdef TT_TIMEOUT_EN
                else if (idle_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
`endif
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_CHECK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CHECK: begin
                if (resp_in != exp_resp) begin
                    if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
                    if (!fev_q) begin
                        fev_d   = 1'b1;
                        fvec_d  = vec_q;
                        fresp_d = resp_in;
                    end
                end
                cov_d[vec_q] = 1'b1;
                state_d = (&cov_d) ? S_DONE : S_ARMED;
            end
            default: ;
        endcase

        // start overrides whatever the current state decided this cycle
        if (start) begin
            state_d = S_ARMED;
            cnt_d   = '0;
            cov_d   = '0;
            err_d   = '0;
            fev_d   = 1'b0;
            fvec_d  = '0;
            fresp_d = '0;
`ifdef TT_TIMEOUT_EN
            idle_d    = '0;
            timeout_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            cov_q   <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fvec_q  <= '0;
            fresp_q <= '0;
`ifdef TT_TIMEOUT_EN
            idle_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            cov_q   <= cov_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fvec_q  <= fvec_d;
            fresp_q <= fresp_d;
`ifdef TT_TIMEOUT_EN
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign vec_ready       = (state_q == S_ARMED);
    assign busy            = (state_q == S_ARMED) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done            = (state_q == S_DONE);
    assign pass            = done && (err_q == '0) && !to_flag;
    assign err_cnt         = err_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fvec_q;
    assign first_err_resp  = fresp_q;
    assign timeout         = to_flag;

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker: table-driven sweeps plus hand sequences for abort, reset, saturation and idle.
`timescale 1ns/1ps
module tb_tt_response_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, vec_valid;
    logic [2:0] vec_in, resp_in;
    logic       vec_ready, busy, done, pass, fev, timeout;
    logic [7:0] err_cnt;
    logic [2:0] fvec, fresp;

    logic       st0, vv0;
    logic [2:0] vi0, ri0;
    logic       rdy0, busy0, done0, pass0, fev0, to0;
    logic [1:0] err0;
    logic [2:0] fvec0, fresp0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tt_response_checker #(.SETTLE(2), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_in(vec_in), .resp_in(resp_in), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_valid(fev), .first_err_vec(fvec),
        .first_err_resp(fresp), .timeout(timeout));

    tt_response_checker #(.SETTLE(0), .ERR_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .vec_valid(vv0), .vec_ready(rdy0),
        .vec_in(vi0), .resp_in(ri0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_err_valid(fev0), .first_err_vec(fvec0),
        .first_err_resp(fresp0), .timeout(to0));

    typedef struct {
        bit         st;
        logic [2:0] v, r;
        int         e_err;
        bit         e_done, e_pass, e_fev;
        int         e_fvec, e_fresp;
    } tv_t;

    tv_t tbl[$];

    task automatic add(input bit st, input int v, input int r, input int err, input bit dn,
                       input bit ps, input bit fe, input int fv, input int fr);
        tv_t t;
        t.st = st; t.v = 3'(v); t.r = 3'(r); t.e_err = err; t.e_done = dn;
        t.e_pass = ps; t.e_fev = fe; t.e_fvec = fv; t.e_fresp = fr;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ready", vec_ready, 1);
        chk("start_err", err_cnt, 0);
        chk("start_fev", fev, 0);
        chk("start_done", done, 0);
        chk("start_timeout", timeout, 0);
    endtask

    task automatic apply(input logic [2:0] v, input logic [2:0] r);
        int n;
        n = 0;
        while (!vec_ready && n < 20) begin @(negedge clk); n++; end
        if (!vec_ready) chk("wait_ready", 0, 1);
        vec_in = v; resp_in = r; vec_valid = 1'b1;
        @(negedge clk);
        chk("settle_ready_low", vec_ready, 0);
        // keep offering a different vector while one is outstanding; it must be ignored
        vec_in = ~v;
        n = 0;
        while (!(vec_ready || done) && n < 20) begin @(negedge clk); n++; end
        vec_valid = 1'b0;
        if (!(vec_ready || done)) chk("wait_check", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; vec_valid = 0; vec_in = 0; resp_in = 0;
        st0 = 0; vv0 = 0; vi0 = 0; ri0 = 0;

        // correct responses: 0,3,1,2,3,2,6,7
        add(1,0,0,0,0,0,0,0,0); add(0,1,3,0,0,0,0,0,0); add(0,2,1,0,0,0,0,0,0); add(0,3,2,0,0,0,0,0,0);
        add(0,4,3,0,0,0,0,0,0); add(0,5,2,0,0,0,0,0,0); add(0,6,6,0,0,0,0,0,0); add(0,7,7,0,1,1,0,0,0);
        add(1,0,0,0,0,0,0,0,0); add(0,1,3,0,0,0,0,0,0); add(0,2,1,0,0,0,0,0,0); add(0,3,2,0,0,0,0,0,0);
        add(0,4,3,0,0,0,0,0,0); add(0,5,2,0,0,0,0,0,0); add(0,6,0,1,0,0,1,6,0); add(0,7,7,1,1,0,1,6,0);
        add(1,0,0,0,0,0,0,0,0); add(0,1,0,1,0,0,1,1,0); add(0,1,4,2,0,0,1,1,0); add(0,2,1,2,0,0,1,1,0);
        add(0,3,2,2,0,0,1,1,0); add(0,4,3,2,0,0,1,1,0); add(0,5,2,2,0,0,1,1,0); add(0,6,6,2,0,0,1,1,0);
        add(0,7,7,2,1,0,1,1,0);
        add(1,0,0,0,0,0,0,0,0); add(0,1,7,1,0,0,1,1,7); add(0,2,1,1,0,0,1,1,7); add(0,3,2,1,0,0,1,1,7);
        add(1,4,3,0,0,0,0,0,0); add(0,5,2,0,0,0,0,0,0); add(0,6,6,0,0,0,0,0,0); add(0,7,7,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0,0); add(0,1,3,0,0,0,0,0,0); add(0,2,1,0,0,0,0,0,0); add(0,3,2,0,1,1,0,0,0);

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_ready", vec_ready, 0); chk("rst_done", done, 0);
        chk("rst_pass", pass, 0); chk("rst_err", err_cnt, 0); chk("rst_fev", fev, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        vec_valid = 1'b1;
        repeat (2) @(negedge clk);
        vec_valid = 1'b0;
        chk("idle_ignores_valid", busy, 0);

        foreach (tbl[i]) begin
            if (tbl[i].st) pulse_start();
            apply(tbl[i].v, tbl[i].r);
            chk($sformatf("t%0d_err", i), err_cnt, tbl[i].e_err);
            chk($sformatf("t%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("t%0d_fev", i), fev, tbl[i].e_fev);
            if (tbl[i].e_fev) begin
                chk($sformatf("t%0d_fvec", i), fvec, tbl[i].e_fvec);
                chk($sformatf("t%0d_fresp", i), fresp, tbl[i].e_fresp);
            end
            if (tbl[i].e_done) chk($sformatf("t%0d_pass", i), pass, tbl[i].e_pass);
        end

        // asynchronous reset while a vector is settling
        pulse_start();
        apply(3'd1, 3'd0);
        chk("pre_rst_err", err_cnt, 1);
        vec_in = 3'd2; resp_in = 3'd1; vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        chk("in_settle_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0); chk("async_err", err_cnt, 0); chk("async_fev", fev, 0);
        chk("async_fvec", fvec, 0); chk("async_ready", vec_ready, 0); chk("async_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", busy, 0);

        // SETTLE=0: compare one cycle after acceptance; 2-bit error counter saturates
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        chk("s0_ready", rdy0, 1);
        for (int k = 1; k <= 4; k++) begin
            vi0 = 3'd0; ri0 = 3'd7; vv0 = 1'b1;
            @(negedge clk);
            vv0 = 1'b0;
            if (k == 1) begin
                chk("s0_not_yet", err0, 0);
                chk("s0_in_check", rdy0, 0);
            end
            @(negedge clk);
            chk($sformatf("s0_err%0d", k), err0, (k > 3) ? 3 : k);
        end
        chk("s0_done", done0, 0);

        // idle watchdog after three vectors
        pulse_start();
        apply(3'd0, 3'd0); apply(3'd1, 3'd3); apply(3'd2, 3'd1);
`ifdef TT_TIMEOUT_EN
        begin
            int n;
            repeat (10) @(negedge clk);
            chk("to_early", done, 0);
            n = 0;
            while (!done && n < 40) begin @(negedge clk); n++; end
            chk("to_done", done, 1); chk("to_flag", timeout, 1);
            chk("to_pass", pass, 0); chk("to_err_kept", err_cnt, 0);
        end
`else
        repeat (30) @(negedge clk);
        chk("no_to_flag", timeout, 0); chk("no_to_done", done, 0); chk("no_to_ready", vec_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
